// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and forwarding-source codes for the hazard scoreboard slice.
//   XLEN_DEF / NREG_DEF / CNTW_DEF : default datapath width, register count, counter width
//   FWD_*                         : forwarding source selected by one read port
package hazard_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int CNTW_DEF = 16;

    typedef logic [2:0] fwd_src_t;

    localparam fwd_src_t FWD_NONE = 3'd0;
    localparam fwd_src_t FWD_EX   = 3'd1;
    localparam fwd_src_t FWD_MEM  = 3'd2;
    localparam fwd_src_t FWD_WB   = 3'd3;
    localparam fwd_src_t FWD_LC   = 3'd4;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit bundle.
//   master : pipeline side, drives ID/EX/MEM/WB/MDU status, receives stall/flush/forwarding
//   slave  : hazard_scoreboard side
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int CNTW = CNTW_DEF,
    parameter int AW   = $clog2(NREG)
);
    logic            re1_ID, re2_ID;
    logic [AW-1:0]   rR1_ID, rR2_ID;
    logic            we_ID;
    logic [AW-1:0]   wR_ID;
    logic            long_ID;
    logic            mdu_full;
    logic            rf_we_EX, rf_we_MEM, rf_we_WB;
    logic [AW-1:0]   wR_EX, wR_MEM, wR_WB;
    logic [XLEN-1:0] wD_EX, wD_MEM, wD_WB;
    logic            load_EX;
    logic            npc_op;
    logic            lc_done;
    logic [AW-1:0]   lc_wR;
    logic [XLEN-1:0] lc_wD;
    logic            cnt_clr;
    logic            stall_PC, stall_IF_ID;
    logic            flush_IF_ID, flush_ID_EX;
    logic            rD1_op, rD2_op;
    logic [XLEN-1:0] rD1_f, rD2_f;
    logic [NREG-1:0] pend;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    modport master (
        output re1_ID, re2_ID, rR1_ID, rR2_ID, we_ID, wR_ID, long_ID, mdu_full,
               rf_we_EX, rf_we_MEM, rf_we_WB, wR_EX, wR_MEM, wR_WB,
               wD_EX, wD_MEM, wD_WB, load_EX, npc_op, lc_done, lc_wR, lc_wD, cnt_clr,
        input  stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX,
               rD1_op, rD2_op, rD1_f, rD2_f, pend, stall_cnt, flush_cnt
    );

    modport slave (
        input  re1_ID, re2_ID, rR1_ID, rR2_ID, we_ID, wR_ID, long_ID, mdu_full,
               rf_we_EX, rf_we_MEM, rf_we_WB, wR_EX, wR_MEM, wR_WB,
               wD_EX, wD_MEM, wD_WB, load_EX, npc_op, lc_done, lc_wR, lc_wD, cnt_clr,
        output stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX,
               rD1_op, rD2_op, rD1_f, rD2_f, pend, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_fwd.sv
// hz_fwd_port: forwarding match and priority mux for one ID read port.
//   re, rr           : read enable / source index
//   *_ex/_mem/_wb    : stage write enable, destination, data
//   lc_*             : MDU writeback (lowest priority source)
//   op, f            : any-match flag and forwarded data (0 when no match)
//   ex_hit           : EX stage matched, used for load-use detection
module hz_fwd_port
    import hazard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5
) (
    input  logic            re,
    input  logic [AW-1:0]   rr,
    input  logic            we_ex,
    input  logic [AW-1:0]   wr_ex,
    input  logic [XLEN-1:0] wd_ex,
    input  logic            we_mem,
    input  logic [AW-1:0]   wr_mem,
    input  logic [XLEN-1:0] wd_mem,
    input  logic            we_wb,
    input  logic [AW-1:0]   wr_wb,
    input  logic [XLEN-1:0] wd_wb,
    input  logic            lc_done,
    input  logic [AW-1:0]   lc_wr,
    input  logic [XLEN-1:0] lc_wd,
    output logic            op,
    output logic [XLEN-1:0] f,
    output logic            ex_hit
);

    logic     rd_live;
    logic     hit_mem, hit_wb, hit_lc;
    fwd_src_t src;

    // x0 is hardwired zero, so it never takes forwarded data
    assign rd_live = re & (rr != '0);
    assign ex_hit  = rd_live & we_ex   & (wr_ex  == rr);
    assign hit_mem = rd_live & we_mem  & (wr_mem == rr);
    assign hit_wb  = rd_live & we_wb   & (wr_wb  == rr);
    assign hit_lc  = rd_live & lc_done & (lc_wr  == rr);

    // youngest producer wins
    always_comb begin
        src = FWD_NONE;
        if (ex_hit)       src = FWD_EX;
        else if (hit_mem) src = FWD_MEM;
        else if (hit_wb)  src = FWD_WB;
        else if (hit_lc)  src = FWD_LC;
    end

    always_comb begin
        f = '0;
        case (src)
            FWD_EX:  f = wd_ex;
            FWD_MEM: f = wd_mem;
            FWD_WB:  f = wd_wb;
            FWD_LC:  f = lc_wd;
            default: f = '0;
        endcase
    end

    assign op = (src != FWD_NONE);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit with a long-latency (MDU) scoreboard.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   hz       : slave side of hazard_scoreboard_if
//              stall/flush and forwarding outputs are combinational;
//              pend (outstanding MDU destinations) and the saturating
//              stall/flush counters are registered.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int CNTW = CNTW_DEF
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave hz
);

    logic [NREG-1:0] pend_q, pend_nxt;
    logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;
    logic            ex_hit1, ex_hit2;
    logic            load_use, raw1, raw2, raw_sb, waw_sb, struct_hz;
    logic            stall, issue;

    hz_fwd_port #(.XLEN(XLEN), .AW(AW)) u_fwd1 (
        .re(hz.re1_ID), .rr(hz.rR1_ID),
        .we_ex(hz.rf_we_EX),   .wr_ex(hz.wR_EX),   .wd_ex(hz.wD_EX),
        .we_mem(hz.rf_we_MEM), .wr_mem(hz.wR_MEM), .wd_mem(hz.wD_MEM),
        .we_wb(hz.rf_we_WB),   .wr_wb(hz.wR_WB),   .wd_wb(hz.wD_WB),
        .lc_done(hz.lc_done),  .lc_wr(hz.lc_wR),   .lc_wd(hz.lc_wD),
        .op(hz.rD1_op), .f(hz.rD1_f), .ex_hit(ex_hit1)
    );

    hz_fwd_port #(.XLEN(XLEN), .AW(AW)) u_fwd2 (
        .re(hz.re2_ID), .rr(hz.rR2_ID),
        .we_ex(hz.rf_we_EX),   .wr_ex(hz.wR_EX),   .wd_ex(hz.wD_EX),
        .we_mem(hz.rf_we_MEM), .wr_mem(hz.wR_MEM), .wd_mem(hz.wD_MEM),
        .we_wb(hz.rf_we_WB),   .wr_wb(hz.wR_WB),   .wd_wb(hz.wD_WB),
        .lc_done(hz.lc_done),  .lc_wr(hz.lc_wR),   .lc_wd(hz.lc_wD),
        .op(hz.rD2_op), .f(hz.rD2_f), .ex_hit(ex_hit2)
    );

    assign load_use = hz.load_EX & (ex_hit1 | ex_hit2);

    // A same-cycle MDU writeback to the register resolves the hazard: the
    // value is forwarded from the LC path instead of waiting.
    assign raw1 = hz.re1_ID & (hz.rR1_ID != '0) & pend_q[hz.rR1_ID]
                & ~(hz.lc_done & (hz.lc_wR == hz.rR1_ID));
    assign raw2 = hz.re2_ID & (hz.rR2_ID != '0) & pend_q[hz.rR2_ID]
                & ~(hz.lc_done & (hz.lc_wR == hz.rR2_ID));
    assign raw_sb = raw1 | raw2;

    assign waw_sb = hz.we_ID & (hz.wR_ID != '0) & pend_q[hz.wR_ID]
                  & ~(hz.lc_done & (hz.lc_wR == hz.wR_ID));

    assign struct_hz = hz.long_ID & hz.mdu_full;

    // a taken branch kills the ID instruction, so its hazards are moot
    assign stall = (load_use | raw_sb | waw_sb | struct_hz) & ~hz.npc_op;

    assign hz.stall_PC    = stall;
    assign hz.stall_IF_ID = stall;
    assign hz.flush_IF_ID = hz.npc_op;
    assign hz.flush_ID_EX = stall | hz.npc_op;

    assign issue = hz.long_ID & hz.we_ID & (hz.wR_ID != '0) & ~stall & ~hz.npc_op;

    // clear first so a new issue to the same register overrides the writeback
    always_comb begin
        pend_nxt = pend_q;
        if (hz.lc_done) pend_nxt[hz.lc_wR] = 1'b0;
        if (issue)      pend_nxt[hz.wR_ID] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (hz.cnt_clr) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall && (stall_cnt_q != '1))
                    stall_cnt_q <= stall_cnt_q + CNTW'(1);
                if (hz.npc_op && (flush_cnt_q != '1))
                    flush_cnt_q <= flush_cnt_q + CNTW'(1);
            end
        end
    end

    assign hz.pend      = pend_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule
